// File: rtl/spi_transaction_sequencer.sv
// spi_transaction_sequencer: frames each chip-select window into an address byte plus payload,
// loads selector responses into the transmit register, caps payload length and aborts stalled transfers.
module spi_transaction_sequencer #(
    parameter int MAX_PAYLOAD    = 255,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cs_active_in,
    input  logic [7:0] rx_data_in,
    input  logic       rx_data_in_valid,
    output logic [7:0] address_out,
    output logic       address_out_valid,
    output logic [7:0] payload_data_out,
    output logic       payload_data_out_valid,
    input  logic [7:0] response_data_in,
    input  logic       response_data_in_valid,
    output logic [7:0] tx_data_out,
    output logic       tx_data_out_load,
    output logic [7:0] byte_count_out,
    output logic       overflow_out,
    output logic       timeout_out
);
    typedef enum logic [1:0] {IDLE, ADDRESS, PAYLOAD, ABORT} state_t;
    localparam logic [7:0]  MAX_B   = 8'(MAX_PAYLOAD);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d, pay_q, pay_d, cnt_q, cnt_d, tx_q, tx_d;
    logic        av_q, av_d, pv_q, pv_d, ovf_q, ovf_d, load_q, load_d, to_q, to_d;
    logic [15:0] wd_q, wd_d;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        av_d    = av_q;
        pay_d   = pay_q;
        pv_d    = 1'b0;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        tx_d    = tx_q;
        load_d  = 1'b0;
        wd_d    = wd_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: if (cs_active_in) begin
                state_d = ADDRESS;
                cnt_d   = 8'd0;
                ovf_d   = 1'b0;
                tx_d    = 8'd0;
                wd_d    = 16'd0;
                load_d  = 1'b1;
            end
            ADDRESS, PAYLOAD: if (!cs_active_in) begin
                // chip select release wins over any byte strobed in the same cycle
                state_d = IDLE;
                av_d    = 1'b0;
            end else begin
                if (response_data_in_valid) begin
                    tx_d   = response_data_in;
                    load_d = 1'b1;
                end
                if (rx_data_in_valid) begin
                    wd_d = 16'd0;
                    if (state_q == ADDRESS) begin
                        addr_d  = rx_data_in;
                        av_d    = 1'b1;
                        state_d = PAYLOAD;
                    end else if (cnt_q < MAX_B) begin
                        pay_d = rx_data_in;
                        pv_d  = 1'b1;
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_LAST) begin
                    state_d = ABORT;
                    to_d    = 1'b1;
                    av_d    = 1'b0;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            ABORT: state_d = cs_active_in ? ABORT : IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= 8'd0;
            av_q    <= 1'b0;
            pay_q   <= 8'd0;
            pv_q    <= 1'b0;
            cnt_q   <= 8'd0;
            ovf_q   <= 1'b0;
            tx_q    <= 8'd0;
            load_q  <= 1'b0;
            wd_q    <= 16'd0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            av_q    <= av_d;
            pay_q   <= pay_d;
            pv_q    <= pv_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
            load_q  <= load_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end
    assign address_out            = addr_q;
    assign address_out_valid      = av_q;
    assign payload_data_out       = pay_q;
    assign payload_data_out_valid = pv_q;
    assign tx_data_out            = tx_q;
    assign tx_data_out_load       = load_q;
    assign byte_count_out         = cnt_q;
    assign overflow_out           = ovf_q;
    assign timeout_out            = to_q;
endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// tb_spi_transaction_sequencer: directed transactions checked every cycle against a
// transaction-level model, plus literal expectations at the key points.
module tb_spi_transaction_sequencer;
    localparam int MAXP = 2;
    localparam int TMO  = 16;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs_active_in = 1'b0;
    logic [7:0] rx_data_in = 8'd0;
    logic       rx_data_in_valid = 1'b0;
    logic [7:0] response_data_in = 8'd0;
    logic       response_data_in_valid = 1'b0;
    logic [7:0] address_out, payload_data_out, tx_data_out, byte_count_out;
    logic       address_out_valid, payload_data_out_valid, tx_data_out_load, overflow_out, timeout_out;
    int tests = 0;
    int fails = 0;

    spi_transaction_sequencer #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .cs_active_in(cs_active_in),
        .rx_data_in(rx_data_in), .rx_data_in_valid(rx_data_in_valid),
        .address_out(address_out), .address_out_valid(address_out_valid),
        .payload_data_out(payload_data_out), .payload_data_out_valid(payload_data_out_valid),
        .response_data_in(response_data_in), .response_data_in_valid(response_data_in_valid),
        .tx_data_out(tx_data_out), .tx_data_out_load(tx_data_out_load),
        .byte_count_out(byte_count_out), .overflow_out(overflow_out), .timeout_out(timeout_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Transaction-level model: a window is "live" until cs drops or the watchdog fires ("dead").
    bit         live, dead, have_addr;
    int         quiet;
    logic [7:0] m_addr, m_pay, m_tx;
    int         m_cnt;
    bit         m_av, m_pv, m_ovf, m_load, m_to;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            live = 0; dead = 0; have_addr = 0; quiet = 0;
            m_addr = 0; m_pay = 0; m_tx = 0; m_cnt = 0;
            m_av = 0; m_pv = 0; m_ovf = 0; m_load = 0; m_to = 0;
        end else begin
            m_pv = 0; m_load = 0; m_to = 0;
            if (dead) begin
                if (!cs_active_in) dead = 0;
            end else if (!live) begin
                if (cs_active_in) begin
                    live = 1; have_addr = 0; quiet = 0;
                    m_cnt = 0; m_ovf = 0; m_tx = 0; m_load = 1;
                end
            end else if (!cs_active_in) begin
                live = 0; m_av = 0;
            end else begin
                if (response_data_in_valid) begin m_tx = response_data_in; m_load = 1; end
                if (rx_data_in_valid) begin
                    quiet = 0;
                    if (!have_addr) begin have_addr = 1; m_addr = rx_data_in; m_av = 1; end
                    else if (m_cnt < MAXP) begin m_pay = rx_data_in; m_pv = 1; m_cnt++; end
                    else m_ovf = 1;
                end else if (quiet + 1 == TMO) begin
                    live = 0; dead = 1; m_to = 1; m_av = 0;
                end else quiet++;
            end
        end
    end

    always @(negedge clock) if (reset_n) begin
        chk("address", address_out, m_addr);
        chk("address_valid", address_out_valid, m_av);
        chk("payload_valid", payload_data_out_valid, m_pv);
        if (m_pv) chk("payload", payload_data_out, m_pay);
        chk("tx_data", tx_data_out, m_tx);
        chk("tx_load", tx_data_out_load, m_load);
        chk("byte_count", byte_count_out, 16'(m_cnt));
        chk("overflow", overflow_out, m_ovf);
        chk("timeout", timeout_out, m_to);
    end

    task automatic step(input logic cs, input logic rv, input logic [7:0] rx,
                        input logic sv, input logic [7:0] rsp);
        cs_active_in = cs; rx_data_in_valid = rv; rx_data_in = rx;
        response_data_in_valid = sv; response_data_in = rsp;
        @(posedge clock);
        #2;
    endtask

    task automatic all_zero(input string name);
        chk(name, {address_out, byte_count_out}, 16'h0);
        chk(name, {tx_data_out, payload_data_out}, 16'h0);
        chk(name, 16'({address_out_valid, payload_data_out_valid, tx_data_out_load, overflow_out, timeout_out}), 16'h0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #2;
        all_zero("reset_state");
        reset_n = 1'b1;
        // basic transaction
        step(1, 0, 0, 0, 0);
        chk("entry_load", tx_data_out_load, 1);
        step(1, 1, 8'hA0, 0, 0);
        chk("basic_addr", address_out, 16'hA0);
        chk("basic_av", address_out_valid, 1);
        step(1, 1, 8'h11, 0, 0);
        chk("basic_p1", {payload_data_out_valid, payload_data_out}, 16'h111);
        step(1, 0, 0, 0, 0);
        step(1, 1, 8'h22, 0, 0);
        chk("basic_p2", {payload_data_out_valid, payload_data_out}, 16'h122);
        step(0, 0, 0, 0, 0);
        chk("basic_end", {address_out_valid, byte_count_out}, 16'h002);
        step(0, 0, 0, 0, 0);
        // overflow
        step(1, 0, 0, 0, 0);
        step(1, 1, 8'hB5, 0, 0);
        step(1, 1, 8'h01, 0, 0);
        step(1, 1, 8'h02, 0, 0);
        step(1, 1, 8'h03, 0, 0);
        chk("ovf_drop", {payload_data_out_valid, overflow_out, byte_count_out}, 16'h0102);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("ovf_clear", {overflow_out, byte_count_out}, 16'h0);
        // response loading
        step(1, 1, 8'hA1, 0, 0);
        step(1, 0, 0, 1, 8'h5A);
        chk("resp1", {tx_data_out_load, tx_data_out}, 16'h15A);
        step(1, 1, 8'h10, 1, 8'h7E);
        chk("resp2", {tx_data_out_load, tx_data_out}, 16'h17E);
        step(1, 1, 8'h20, 1, 8'hC3);
        chk("resp3", {tx_data_out_load, tx_data_out}, 16'h1C3);
        step(0, 0, 0, 0, 0);
        // watchdog: timeout 16 cycles after the address strobe
        step(1, 0, 0, 0, 0);
        step(1, 1, 8'hA0, 0, 0);
        repeat (TMO - 1) step(1, 0, 0, 0, 0);
        chk("wd_quiet", timeout_out, 0);
        step(1, 0, 0, 0, 0);
        chk("wd_fire", {timeout_out, address_out_valid}, 16'h2);
        step(1, 1, 8'h55, 1, 8'h99);
        chk("abort_ignore", {payload_data_out_valid, tx_data_out_load, timeout_out}, 16'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // cs release has priority over a same-cycle byte
        step(1, 0, 0, 0, 0);
        step(1, 1, 8'hC0, 0, 0);
        step(1, 1, 8'h44, 0, 0);
        step(0, 1, 8'h33, 0, 0);
        chk("prio", {payload_data_out_valid, address_out_valid, byte_count_out}, 16'h0001);
        step(1, 0, 0, 0, 0);
        chk("prio_restart", tx_data_out_load, 1);
        // async reset mid-payload
        step(1, 1, 8'hD0, 0, 0);
        step(1, 1, 8'h66, 0, 0);
        chk("pre_reset", payload_data_out_valid, 1);
        #1 reset_n = 1'b0;
        #1 all_zero("async_reset");
        @(posedge clock);
        #2 reset_n = 1'b1;
        step(1, 0, 0, 0, 0);
        step(1, 1, 8'h77, 0, 0);
        chk("post_reset_addr", {address_out_valid, address_out}, 16'h177);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_transaction_sequencer.md
# spi_transaction_sequencer

Frames the SPI byte stream into transactions for the subperipheral address decode. The block sits between the SPI shift register and the subperipheral selector: it captures the first byte of each chip-select window as the address, forwards the remaining bytes as payload, and loads subperipheral responses into the transmit register. It also counts payload bytes, enforces a maximum payload length and aborts stalled transactions with a watchdog.

## Interface
Parameters:
- MAX_PAYLOAD, default 255: maximum payload bytes accepted per transaction; range 1..255.
- TIMEOUT_CYCLES, default 65535: clock cycles without a received byte before the transaction is aborted; 0 disables the watchdog; 16-bit counter.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cs_active_in  in  1  chip select, already synchronised to clock; high for the duration of a transaction.
- rx_data_in  in  8  received byte.
- rx_data_in_valid  in  1  one-cycle pulse per received byte.
- address_out  out  8  latched address byte; drives the selector address.
- address_out_valid  out  1  high while the address is valid for the current transaction.
- payload_data_out  out  8  payload byte forwarded to the selector.
- payload_data_out_valid  out  1  one-cycle pulse per forwarded payload byte.
- response_data_in  in  8  response byte returned from the selector.
- response_data_in_valid  in  1  response strobe.
- tx_data_out  out  8  byte the SPI shifter sends next.
- tx_data_out_load  out  1  one-cycle pulse when tx_data_out is updated.
- byte_count_out  out  8  payload bytes accepted in the current or last transaction.
- overflow_out  out  1  sticky per transaction; set when a byte beyond MAX_PAYLOAD is dropped.
- timeout_out  out  1  one-cycle pulse when the watchdog aborts a transaction.

## Operation
- All outputs are registered. While reset_n is low, every output is 0 and the state is IDLE.
- **IDLE:** address_out_valid is 0. If cs_active_in is 1, go to ADDRESS. On entry to ADDRESS:
  - clear byte_count_out, overflow_out, tx_data_out and the watchdog counter;
  - assert tx_data_out_load for one cycle.
- **ADDRESS:** on rx_data_in_valid:
  - latch address_out = rx_data_in and set address_out_valid = 1;
  - go to PAYLOAD.
- **PAYLOAD:** on rx_data_in_valid:
  - if byte_count_out < MAX_PAYLOAD: payload_data_out = rx_data_in, pulse payload_data_out_valid, increment byte_count_out;
  - otherwise: drop the byte, emit no pulse, set overflow_out = 1, and leave byte_count_out at MAX_PAYLOAD.
- **Response path (ADDRESS and PAYLOAD only):** on response_data_in_valid, set tx_data_out = response_data_in and pulse tx_data_out_load. Response strobes are ignored in IDLE and ABORT.
- **Watchdog (ADDRESS and PAYLOAD, TIMEOUT_CYCLES ≠ 0):**
  - the counter resets to 0 on each rx_data_in_valid and increments on every other cycle;
  - when the counter equals TIMEOUT_CYCLES−1 on a cycle with no rx_data_in_valid, go to ABORT, pulse timeout_out, and clear address_out_valid.
- **ABORT:** rx_data_in_valid and response strobes are ignored. When cs_active_in is 0, go to IDLE.
- **cs_active_in = 0 while in ADDRESS or PAYLOAD:** go to IDLE and clear address_out_valid. A byte strobed in the same cycle is dropped: cs_active_in has priority over rx_data_in_valid.
- **Held values in IDLE:** address_out, byte_count_out, overflow_out and tx_data_out keep their values until the next transaction starts.
- **Simultaneous rx_data_in_valid and response_data_in_valid:** both are processed in the same cycle.

## Timing
- Address: address byte strobe at cycle N → address_out and address_out_valid = 1 after edge N+1.
- Payload: payload strobe at cycle N → payload_data_out_valid high for cycle N+1 only; byte_count_out updates at the same edge.
- Response: response strobe at cycle N → tx_data_out and tx_data_out_load valid at N+1.
- End of transaction: cs_active_in sampled 0 at edge N → address_out_valid = 0 after edge N; state is IDLE.
- A new transaction can start on the cycle immediately after returning to IDLE.
- Watchdog: with no strobes after cycle S, timeout_out pulses TIMEOUT_CYCLES cycles after S.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously) and the state is IDLE. After reset release, if cs_active_in is still high, a new transaction begins and the next byte is treated as an address.

## Test plan
- **Basic transaction:** cs high; bytes 0xA0, 0x11, 0x22; cs low → address_out = 0xA0 valid one cycle after the first strobe; payload pulses 0x11 then 0x22; byte_count_out = 2; address_out_valid drops the cycle after cs low.
- **Overflow:** MAX_PAYLOAD = 2; address 0xB5 then payloads 0x01, 0x02, 0x03 → only two payload pulses; overflow_out = 1; byte_count_out = 2. The next transaction clears overflow_out.
- **Response loading:** in PAYLOAD, response 0x5A, then responses 0x7E and 0xC3 strobed in the same cycles as rx bytes → tx_data_out shows 0x5A, 0x7E, 0xC3 in order, each with a one-cycle load pulse.
- **Watchdog:** TIMEOUT_CYCLES = 16; address 0xA0 then no strobes → timeout_out pulses 16 cycles after the address strobe; address_out_valid = 0; later strobes are ignored until cs low, then IDLE.
- **Priority:** cs falls in the same cycle as a payload strobe 0x33 → no payload pulse; byte_count_out unchanged; state is IDLE.
- **Async reset mid-payload:** reset_n low mid-payload → all outputs 0 without waiting for a clock edge. With cs held high, the next byte after release appears on address_out.
